// File: rtl/reboot_scheduler_if.sv
// Request/response bundle between the reboot sources and the multiboot scheduler.
// The scheduler drives the *_o members; the request side drives the *_i members.
interface reboot_scheduler_if;
  logic [2:0]  req_i;
  logic [4:0]  core_id1_i;
  logic [4:0]  core_id2_i;
  logic [2:0]  ack_o;
  logic [2:0]  nack_o;
  logic        busy_o;
  logic [23:0] spi_addr_o;
  logic        mbt_reboot_o;

  modport master (
    output req_i, core_id1_i, core_id2_i,
    input  ack_o, nack_o, busy_o, spi_addr_o, mbt_reboot_o
  );

  modport slave (
    input  req_i, core_id1_i, core_id2_i,
    output ack_o, nack_o, busy_o, spi_addr_o, mbt_reboot_o
  );
endinterface

// File: rtl/reboot_scheduler.sv
// Arbitrates reboot requests, validates the core ID into a flash address, and emits
// one reboot pulse after a settle window, followed by a lockout period.
module reboot_scheduler #(
  parameter int          SETTLE_CYCLES  = 4,
  parameter int          LOCKOUT_CYCLES = 64,
  parameter int          MAX_CORE       = 20,
  parameter logic [11:0] DEFAULT_PAGE   = 12'h0B0
) (
  input  logic              clk_icap,
  input  logic              reset_i,
  reboot_scheduler_if.slave bus
);
  localparam int NUM_REQ = 3;
  localparam int CNT_MAX = (SETTLE_CYCLES > LOCKOUT_CYCLES) ? SETTLE_CYCLES : LOCKOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_FIRE    = 3'd3;
  localparam logic [2:0] S_LOCKOUT = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [NUM_REQ-1:0] req_q, pend_q, pend_d, rise, grant_clr;
  logic               arm_q;
  logic [1:0]         sel_q, sel_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d, nack_q, nack_d;
  logic               mbt_q, mbt_d;
  logic [23:0]        addr_q, addr_d;
  logic [4:0]         id;
  logic               id_ok;
  logic [11:0]        page;

  // arm_q masks the first clock after reset so a level already high is not an edge
  for (genvar n = 0; n < NUM_REQ; n++) begin : g_edge
    assign rise[n]   = arm_q & bus.req_i[n] & ~req_q[n];
    assign pend_d[n] = rise[n] | (pend_q[n] & ~grant_clr[n]);
  end

  assign id    = (sel_q == 2'd2) ? bus.core_id2_i : bus.core_id1_i;
  assign id_ok = (sel_q == 2'd0) || (id != 5'd0 && id <= 5'(MAX_CORE));
  assign page  = (sel_q == 2'd0) ? DEFAULT_PAGE : 12'(12'h0C4 * {7'd0, id} - 12'h014);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    ack_d     = '0;
    nack_d    = '0;
    mbt_d     = 1'b0;
    grant_clr = '0;
    case (state_q)
      S_IDLE: begin
        if (pend_q != '0) begin
          sel_d     = pend_q[0] ? 2'd0 : (pend_q[1] ? 2'd1 : 2'd2);
          grant_clr = 3'b001 << sel_d;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (id_ok) begin
          addr_d  = {page, 12'h000};
          ack_d   = 3'b001 << sel_q;
          cnt_d   = CW'(SETTLE_CYCLES - 1);
          state_d = S_SETTLE;
        end else begin
          nack_d  = 3'b001 << sel_q;
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          mbt_d   = 1'b1;
          state_d = S_FIRE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_FIRE: begin
        cnt_d   = CW'(LOCKOUT_CYCLES - 1);
        state_d = S_LOCKOUT;
      end
      S_LOCKOUT: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_icap or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      pend_q  <= '0;
      arm_q   <= 1'b0;
      sel_q   <= 2'd0;
      cnt_q   <= '0;
      ack_q   <= '0;
      nack_q  <= '0;
      mbt_q   <= 1'b0;
      addr_q  <= {DEFAULT_PAGE, 12'h000};
    end else begin
      state_q <= state_d;
      req_q   <= bus.req_i;
      pend_q  <= pend_d;
      arm_q   <= 1'b1;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
      mbt_q   <= mbt_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.ack_o        = ack_q;
  assign bus.nack_o       = nack_q;
  assign bus.mbt_reboot_o = mbt_q;
  assign bus.spi_addr_o   = addr_q;
  assign bus.busy_o       = (state_q != S_IDLE);
endmodule
